// File: rtl/data_bus_ram_if.sv
// Load/store bus between the RV32I core (master) and its data memory (slave).
// Signals: addr, dataBusOut, wrEn, rdEn, RamMode from the core;
//          dataBusIn, dataBusInEn, misalign, fault back to the core.
interface data_bus_ram_if;
  logic [31:0] addr;
  logic [31:0] dataBusOut;
  logic        wrEn;
  logic        rdEn;
  logic [3:0]  RamMode;
  logic [31:0] dataBusIn;
  logic        dataBusInEn;
  logic        misalign;
  logic        fault;

  modport master (
    output addr, dataBusOut, wrEn, rdEn, RamMode,
    input  dataBusIn, dataBusInEn, misalign, fault
  );

  modport slave (
    input  addr, dataBusOut, wrEn, rdEn, RamMode,
    output dataBusIn, dataBusInEn, misalign, fault
  );
endinterface

// File: rtl/data_bus_ram.sv
// Data memory for the RV32I load/store bus. Stores commit with byte-lane
// enables at the edge ending the request cycle; loads return extracted,
// sign/zero-extended data two edges after the request. Misaligned,
// out-of-range and malformed requests are flagged one cycle later.
// Ports:
//   clk   - system clock, rising edge
//   rstB  - synchronous active-low reset
//   bus   - data_bus_ram_if.slave (request in, response and flags out)
module data_bus_ram #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic           clk,
  input  logic           rstB,
  data_bus_ram_if.slave  bus
);

  localparam int unsigned AW   = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN = 32'(DEPTH_WORDS * 4);

  logic [31:0] mem [0:DEPTH_WORDS-1];

  // Request decode
  logic [31:0]   offset;
  logic [1:0]    lane;
  logic [AW-1:0] widx;
  logic          is_byte, is_half, is_word, is_uns;
  logic          mode_ok, aligned, in_range, legal;
  logic          acc, collide, we, rd_acc;
  logic [3:0]    be;
  logic [31:0]   wdata;

  // Load pipeline stage 1
  logic          s1_valid;
  logic [31:0]   s1_word;
  logic [1:0]    s1_lane;
  logic          s1_byte, s1_half, s1_uns, s1_err;
  logic [31:0]   ext;
  logic [7:0]    sel_b;
  logic [15:0]   sel_h;

  assign offset   = bus.addr - BASE_ADDR;
  assign lane     = offset[1:0];
  assign widx     = offset[AW+1:2];
  assign in_range = offset < SPAN;

  assign is_byte  = bus.RamMode[3];
  assign is_half  = bus.RamMode[2];
  assign is_word  = bus.RamMode[1];
  assign is_uns   = bus.RamMode[0];
  assign mode_ok  = (bus.RamMode[3:1] == 3'b100) || (bus.RamMode[3:1] == 3'b010) ||
                    (bus.RamMode[3:1] == 3'b001);
  assign aligned  = is_byte || (is_half && !lane[0]) || (is_word && (lane == 2'b00));
  assign legal    = mode_ok && aligned && in_range;

  assign acc      = bus.rdEn || bus.wrEn;
  assign collide  = bus.rdEn && bus.wrEn;
  assign we       = rstB && bus.wrEn && legal;
  // A collision is served as a store only, so no load enters the pipe.
  assign rd_acc   = rstB && bus.rdEn && !bus.wrEn;

  // Lane enables and lane-replicated store data
  always_comb begin
    be    = 4'b0000;
    wdata = bus.dataBusOut;
    if (is_byte) begin
      be    = 4'(4'b0001 << lane);
      wdata = {4{bus.dataBusOut[7:0]}};
    end else if (is_half) begin
      be    = lane[1] ? 4'b1100 : 4'b0011;
      wdata = {2{bus.dataBusOut[15:0]}};
    end else if (is_word) begin
      be    = 4'b1111;
    end
  end

  // Byte-lane memory write; contents are never reset
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[widx][i*8 +: 8] <= wdata[i*8 +: 8];
      end
    end
  end

  // Stage 1 payload: raw word plus everything needed for extraction
  always_ff @(posedge clk) begin
    if (rd_acc) begin
      s1_word <= mem[widx];
      s1_lane <= lane;
      s1_byte <= is_byte;
      s1_half <= is_half;
      s1_uns  <= is_uns;
      s1_err  <= !legal;
    end
  end

  // Lane extraction and extension; illegal loads return zero
  always_comb begin
    sel_b = s1_word[7:0];
    case (s1_lane)
      2'd1:    sel_b = s1_word[15:8];
      2'd2:    sel_b = s1_word[23:16];
      2'd3:    sel_b = s1_word[31:24];
      default: sel_b = s1_word[7:0];
    endcase
    sel_h = s1_lane[1] ? s1_word[31:16] : s1_word[15:0];
    ext   = 32'h0;
    if (!s1_err) begin
      if (s1_byte)      ext = {{24{!s1_uns && sel_b[7]}}, sel_b};
      else if (s1_half) ext = {{16{!s1_uns && sel_h[15]}}, sel_h};
      else              ext = s1_word;
    end
  end

  // Valid bits, response register and error pulses
  always_ff @(posedge clk) begin
    if (!rstB) begin
      s1_valid        <= 1'b0;
      bus.dataBusInEn <= 1'b0;
      bus.dataBusIn   <= 32'h0;
      bus.misalign    <= 1'b0;
      bus.fault       <= 1'b0;
    end else begin
      s1_valid        <= bus.rdEn && !bus.wrEn;
      bus.dataBusInEn <= s1_valid;
      if (s1_valid) bus.dataBusIn <= ext;
      bus.misalign    <= acc && mode_ok && !aligned;
      bus.fault       <= acc && (!in_range || !mode_ok || collide);
    end
  end

endmodule

// File: doc/data_bus_ram.md
# data_bus_ram

Data-memory responder for the RV32I core's load/store bus: it sits at the far end of `addr`/`dataBusOut`/`wrEn`/`rdEn`/`RamMode` and returns `dataBusIn`/`dataBusInEn`. Stores commit with byte-lane enables. Loads return extracted, sign- or zero-extended data exactly two clock edges after the request, which is the cycle in which the core's write-back stage consumes `dataBusIn`. The block also flags misaligned, out-of-range and malformed accesses.

## Interface
Parameters:
- `DEPTH_WORDS`, default 1024: number of 32-bit words; power of two, 16 or more.
- `BASE_ADDR`, default 32'h0000_0000: byte address of word 0; aligned to `DEPTH_WORDS*4`.

Ports (one clock; reset is synchronous and active-low):
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rstB`  in  1  synchronous active-low reset.
- `addr`  in  32  byte address of the request.
- `dataBusOut`  in  32  store data from the core; lane 0 is in [7:0].
- `wrEn`  in  1  store request, valid for the current cycle.
- `rdEn`  in  1  load request, valid for the current cycle.
- `RamMode`  in  4  {byte, half, word, unsigned}.
- `dataBusIn`  out  32  load data to the core.
- `dataBusInEn`  out  1  one-cycle strobe; `dataBusIn` is valid while it is high.
- `misalign`  out  1  one-cycle pulse for a misaligned access.
- `fault`  out  1  one-cycle pulse for an out-of-range address, an invalid mode, or `rdEn` and `wrEn` asserted together.

## Operation
- **Request acceptance.** A request is accepted in any cycle T where `rstB` is 1 and `rdEn` or `wrEn` is 1. There is no backpressure, and a new request may arrive every cycle.
- **Mode decode.**
  - The mode is valid only when exactly one of `RamMode[3:1]` is set.
  - Word with unsigned set is treated as word.
- **Alignment.**
  - Half requires `addr[0]`=0.
  - Word requires `addr[1:0]`=0.
  - Byte is always aligned.
- **Range.** `offset = addr - BASE_ADDR` (32-bit, wraps). The access is in range iff `offset < DEPTH_WORDS*4`. Word index is `offset[log2(DEPTH_WORDS)+1:2]`.
- **Store.**
  - Byte: writes lane `addr[1:0]` with `dataBusOut[7:0]`.
  - Half: writes lanes {`addr[1]`*2, +1} with `dataBusOut[15:0]`.
  - Word: writes all four lanes.
  - Other lanes are unchanged.
  - The store commits at the end of cycle T.
- **Load pipeline.**
  - Stage 1, edge ending T: registers the word read, the lane select, the mode, and a valid bit.
  - Stage 2, edge ending T+1: registers the extracted value into `dataBusIn` and sets `dataBusInEn`.
  - Byte/half data is sign-extended from bit 7/15, or zero-extended when unsigned.
- **Illegal accesses.**
  - Any misaligned, out-of-range or invalid-mode access performs no write.
  - A misaligned, out-of-range or invalid-mode load still produces `dataBusInEn`, with `dataBusIn`=0.
- **rdEn and wrEn in the same cycle.** The request is treated as the store (write performed if otherwise legal), `fault` pulses, and no load response is produced.
- **Load/store ordering.** A store at T followed by a load of the same word at T+1 returns the stored data (read-after-write across cycles). A load at T and a store at T+1 to the same word: the load returns pre-store data.
- **Memory contents.** Not initialised and not cleared by reset.

## Timing
- **Reset values.** `dataBusIn`=0, `dataBusInEn`=0, `misalign`=0, `fault`=0, and both pipeline valid bits=0.
- **Load latency.** Request in cycle T gives `dataBusInEn`=1 and valid `dataBusIn` during cycle T+2, for exactly one cycle.
- **Back-to-back loads.** Loads at T and T+1 give responses at T+2 and T+3.
- **Output hold.** `dataBusIn` holds its last value when `dataBusInEn`=0. Only reset zeroes it.
- **Store latency.** A store has zero response latency: memory is updated at the edge ending T.
- **Error flags.** `misalign` and `fault` pulse during T+1, registered at the edge ending T. Both may be high together.
- **Reset mid-operation.** `rstB`=0 at any edge clears the stage valid bits. In-flight loads produce no `dataBusInEn`. A store in a cycle with `rstB`=0 is not written.

## Test plan
- **Word round trip.** Store word 32'hDEAD_BEEF to 0x10 at T, load word 0x10 at T+1 -> `dataBusIn`=32'hDEAD_BEEF with `dataBusInEn`=1 in T+3 only.
- **Byte and half extraction.** After the word at 0x10, load byte 0x13 signed -> 32'hFFFF_FFDE. Load byte 0x13 unsigned -> 32'h0000_00DE. Load half 0x10 signed -> 32'hFFFF_BEEF.
- **Partial stores.** Store byte 8'h55 to 0x11, then store half 16'h1234 to 0x12 -> load word 0x10 returns 32'h1234_55EF.
- **Misaligned access.** Word store to 0x22 -> no memory change, `misalign`=1 at T+1. Half load at 0x21 -> `dataBusIn`=0 with `dataBusInEn`=1 at T+2.
- **Out-of-range and invalid mode.** With `DEPTH_WORDS`=1024, load at 0x1000 -> `fault`=1 at T+1, `dataBusIn`=0. `RamMode`=4'b1100 store -> `fault`=1, no write.
- **Reset and collision.** Loads at T and T+1 with `rstB`=0 at the edge ending T+1 -> no `dataBusInEn` in T+2 or T+3, outputs at 0. `rdEn`=`wrEn`=1 -> write occurs, `fault`=1, no response strobe.
